// File: rtl/ex_muldiv_seq_if.sv
// Execute-stage port bundle for the iterative multiply/divide sequencer.
//
// Handshake: the pipeline (master) raises start_i with op_i/src_a_i/src_b_i
// and holds start_i high for as long as stall_o is high. The sequencer
// (slave) samples operands only in the IDLE cycle where start_i is seen,
// keeps stall_o high through CALC and FIX, then drops stall_o and raises
// done_o for exactly one cycle with result_o valid; that is the cycle the
// Execute/Memory register captures the result. flush_i, or start_i falling
// before DONE, abandons the operation with no done_o.
interface ex_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] src_a_i;
  logic [XLEN-1:0] src_b_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [1:0]      state_o;

  modport master (
    output start_i, op_i, src_a_i, src_b_i, flush_i,
    input  stall_o, busy_o, done_o, result_o, state_o
  );

  modport slave (
    input  start_i, op_i, src_a_i, src_b_i, flush_i,
    output stall_o, busy_o, done_o, result_o, state_o
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the Execute stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// sign/special-case fix-up in a dedicated FIX cycle, fixed XLEN+3 latency.
module ex_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  ex_muldiv_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  // hi/lo: product accumulator for multiply, remainder/quotient for divide
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   result_q;

  logic              go;
  logic              step;
  logic              fix_en;

  // Operand decode in the start cycle
  logic              signed_a_op;
  logic              signed_b_op;
  logic              neg_a_in;
  logic              neg_b_in;
  logic [XLEN-1:0]   abs_a_in;
  logic [XLEN-1:0]   abs_b_in;

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ok;

  // Fix-up datapath
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   a_orig;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   fix_val;

  // Next-state and per-cycle enables; flush wins over everything but rst
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    step      = 1'b0;
    fix_en    = 1'b0;
    if (bus.flush_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            state_nxt = S_CALC;
            go        = 1'b1;
          end
        end
        S_CALC: begin
          if (!bus.start_i) begin
            state_nxt = S_IDLE;
          end else begin
            step = 1'b1;
            if (cnt == LAST_ITER) state_nxt = S_FIX;
          end
        end
        S_FIX: begin
          if (!bus.start_i) begin
            state_nxt = S_IDLE;
          end else begin
            fix_en    = 1'b1;
            state_nxt = S_DONE;
          end
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Operand sign handling: MULH/DIV/REM signed on both, MULHSU on A only
  always_comb begin
    signed_a_op = (bus.op_i == 3'b001) || (bus.op_i == 3'b010) ||
                  (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
    signed_b_op = (bus.op_i == 3'b001) || (bus.op_i == 3'b100) ||
                  (bus.op_i == 3'b110);
    neg_a_in    = signed_a_op & bus.src_a_i[XLEN-1];
    neg_b_in    = signed_b_op & bus.src_b_i[XLEN-1];
    abs_a_in    = neg_a_in ? (~bus.src_a_i + 1'b1) : bus.src_a_i;
    abs_b_in    = neg_b_in ? (~bus.src_b_i + 1'b1) : bus.src_b_i;
  end

  // One radix-2 step of multiply (add-then-shift) and restoring divide
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : {(XLEN+1){1'b0}});
    div_shift = {hi, lo[XLEN-1]};
    div_ok    = (div_shift >= {1'b0, mag_b});
    div_diff  = div_shift[XLEN-1:0] - mag_b;
  end

  // Sign correction and RISC-V divide special cases
  always_comb begin
    prod     = {hi, lo};
    prod_fix = (sign_a ^ sign_b) ? (~prod + 1'b1) : prod;
    quo_fix  = (sign_a ^ sign_b) ? (~lo + 1'b1) : lo;
    rem_fix  = sign_a ? (~hi + 1'b1) : hi;
    a_orig   = sign_a ? (~mag_a + 1'b1) : mag_a;
    div_zero = (mag_b == {XLEN{1'b0}});
    div_ovf  = sign_a & sign_b & (mag_a == MIN_NEG) & (mag_b == XLEN'(1));
    fix_val  = '0;
    case (op_q)
      3'b000:                 fix_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (div_zero)      fix_val = {XLEN{1'b1}};
        else if (div_ovf)  fix_val = MIN_NEG;
        else               fix_val = quo_fix;
      end
      default: begin
        if (div_zero)      fix_val = a_orig;
        else if (div_ovf)  fix_val = '0;
        else               fix_val = rem_fix;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Operand latch, iteration registers and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      op_q     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      hi       <= '0;
      lo       <= '0;
      result_q <= '0;
    end else begin
      if (go) begin
        cnt    <= '0;
        op_q   <= bus.op_i;
        sign_a <= neg_a_in;
        sign_b <= neg_b_in;
        mag_a  <= abs_a_in;
        mag_b  <= abs_b_in;
        hi     <= '0;
        lo     <= bus.op_i[2] ? abs_a_in : abs_b_in;
      end
      if (step) begin
        cnt <= cnt + CNT_W'(1);
        if (!op_q[2]) begin
          hi <= mul_sum[XLEN:1];
          lo <= {mul_sum[0], lo[XLEN-1:1]};
        end else if (div_ok) begin
          hi <= div_diff;
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= div_shift[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end
      if (fix_en) result_q <= fix_val;
    end
  end

  assign bus.stall_o  = bus.start_i & ~bus.flush_i & (state != S_DONE);
  assign bus.done_o   = (state == S_DONE) & ~bus.flush_i;
  assign bus.busy_o   = (state != S_IDLE);
  assign bus.result_o = result_q;
  assign bus.state_o  = state;

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
Sequencer for an iterative RV32M multiply/divide unit attached to the Execute stage. It holds an M-extension op in Execute by raising a stall to the hazard logic. It runs a fixed-latency radix-2 shift-add multiply or restoring divide on the forwarded operands (post-forwarding SrcA / WriteData values). In its final cycle it presents the result so the Execute/Memory register can capture it.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
start_i  input  1  M-op valid in Execute; held high by pipeline while stalled
op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a_i  input  XLEN  forwarded operand A (rs1)
src_b_i  input  XLEN  forwarded operand B (rs2)
flush_i  input  1  Execute-stage flush from hazard unit
stall_o  output  1  stall request for Fetch/Decode/Execute
busy_o  output  1  sequencer not in IDLE
done_o  output  1  result valid this cycle
result_o  output  XLEN  op result

Behaviour:
- Reset and interface: one clock, clk. rst is synchronous and active-high. rst forces state=IDLE, counter=0, result_o=0, done_o=0, busy_o=0. Internal accumulators are cleared. rst mid-operation aborts with no further output.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start_i=1, flush_i=0:
  - Latch op_i.
  - Latch operand magnitudes and sign flags. Signed ops are MULH/DIV/REM for both operands, and MULHSU for A only.
  - Go to CALC; counter=0.
- CALC:
  - One iteration per cycle, exactly XLEN cycles; counter increments.
  - Multiply: 2*XLEN-bit unsigned product accumulator.
  - Divide: restoring shift-subtract into XLEN-bit quotient and remainder.
  - At counter==XLEN-1, go to FIX.
- FIX (1 cycle): apply sign correction and special cases, then register result_o.
  - MUL: low XLEN bits of the signed-corrected product.
  - MULH, MULHSU, MULHU: high XLEN bits. The product is negated (two's complement, 2*XLEN) when the operand signs differ.
  - DIV, REM: quotient negated if sign_a^sign_b; remainder takes sign of A.
  - Divisor==0: quotient=all ones, remainder=A (unsigned and signed).
  - Signed overflow (A=0x80000000, B=-1): quotient=0x80000000, remainder=0.
  - Special cases run the full latency; no early exit.
- DONE (1 cycle): done_o=1, stall_o=0, so the pipeline advances and captures result_o. Next state is IDLE.
- Latency: fixed XLEN+3 cycles in Execute (35 for XLEN=32).
  - Start cycle and CALC/FIX cycles are stalled (XLEN+2 stall cycles).
  - The DONE cycle is unstalled.
- stall_o = start_i & ~flush_i & (state!=DONE). It is combinational and asserted in the IDLE cycle where start_i first rises.
- busy_o = (state!=IDLE), registered-state derived.
- result_o holds its value after DONE until the next FIX.
- flush_i has priority over everything except rst:
  - In any state, the next state is IDLE, and done_o/stall_o are 0 in the flush cycle.
  - Partial results are discarded; result_o is not updated.
- start_i dropping while in CALC/FIX without flush_i: treated as an abort, identical to flush, at the next edge.
- Back-to-back ops: a new start_i in the cycle after DONE (state IDLE) starts immediately. There is no dead cycle beyond the IDLE entry.
- Operands are sampled only in the IDLE start cycle. Later changes to src_a_i/src_b_i (forwarding updates) are ignored.

Test Plan:
1. MUL 7 × 0xFFFFFFFD:
   - stall_o=1 for cycles 0–33.
   - Cycle 34: done_o=1, stall_o=0, result_o=0xFFFFFFEB.
   - Cycle 35: busy_o=0.
2. MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. Each at cycle 34.
3. DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
4. Special cases:
   - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same → 0.
   - All at fixed 35-cycle latency.
5. flush_i pulsed at CALC cycle 10: same-cycle stall_o=0; next cycle state IDLE, busy_o=0; done_o never asserts; result_o unchanged. Repeat with rst=1 at CALC cycle 10: all outputs 0 next cycle.
6. Back-to-back MUL 3×4 then DIVU 9/2: first done_o at cycle 34 (12); second start in cycle 35, done_o at cycle 69 (4). Also check that src_a_i changing during CALC does not alter either result.
